// File: rtl/msrv32_wb_pkg.sv
// Shared encodings for the msrv32 write-back stage: source select, load size, FSM states.
package msrv32_wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    WB_SEL_ALU  = 3'd0,
    WB_SEL_LOAD = 3'd1,
    WB_SEL_CSR  = 3'd2,
    WB_SEL_PC4  = 3'd3,
    WB_SEL_IMM  = 3'd4
  } wb_sel_e;

  typedef enum logic [1:0] {
    LOAD_BYTE = 2'd0,
    LOAD_HALF = 2'd1,
    LOAD_WORD = 2'd2,
    LOAD_RSVD = 2'd3
  } load_size_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/msrv32_wb_stage_if.sv
// Bundle/memory/register-file signals of the write-back stage; master drives stage inputs.
interface msrv32_wb_stage_if;
  import msrv32_wb_pkg::*;

  logic            valid_in;
  logic [4:0]      rd_addr_in;
  logic            rf_wr_en_in;
  logic [2:0]      wb_sel_in;
  logic [XLEN-1:0] alu_result_in;
  logic [XLEN-1:0] csr_data_in;
  logic [XLEN-1:0] pc_plus4_in;
  logic [XLEN-1:0] imm_in;
  logic [1:0]      load_size_in;
  logic            load_unsigned_in;
  logic [XLEN-1:0] dmem_rdata_in;
  logic            dmem_valid_in;
  logic [4:0]      rd_addr_out;
  logic            wr_en_out;
  logic [XLEN-1:0] rd_out;
  logic            stall_out;
  logic            load_fault_out;

  modport master (
    output valid_in, rd_addr_in, rf_wr_en_in, wb_sel_in, alu_result_in, csr_data_in,
           pc_plus4_in, imm_in, load_size_in, load_unsigned_in, dmem_rdata_in, dmem_valid_in,
    input  rd_addr_out, wr_en_out, rd_out, stall_out, load_fault_out
  );

  modport slave (
    input  valid_in, rd_addr_in, rf_wr_en_in, wb_sel_in, alu_result_in, csr_data_in,
           pc_plus4_in, imm_in, load_size_in, load_unsigned_in, dmem_rdata_in, dmem_valid_in,
    output rd_addr_out, wr_en_out, rd_out, stall_out, load_fault_out
  );

endinterface

// File: rtl/msrv32_load_align.sv
// Combinational load lane select with sign/zero extension; reserved size behaves as word.
module msrv32_load_align
  import msrv32_wb_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    // addr[0] is ignored for halves; misaligned halves never reach this stage
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (load_size_e'(size))
      LOAD_BYTE: data = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
      LOAD_HALF: data = {{16{~load_unsigned & half_lane[15]}}, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_wb_stage.sv
// msrv32 write-back stage: registers the stage-2 bundle, waits for load data, drives the register file.
// Optional load timeout is enabled with the WB_LOAD_TIMEOUT_EN macro.
module msrv32_wb_stage
  import msrv32_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset_n_in,
  msrv32_wb_stage_if.slave bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  wb_state_e       state, next_state;
  logic            stall, write_ready, timeout_hit;
  logic            reg_valid, reg_rf_wr_en, reg_load_unsigned;
  logic [4:0]      reg_rd_addr;
  logic [2:0]      reg_wb_sel;
  logic [1:0]      reg_load_size;
  logic [XLEN-1:0] reg_alu, reg_csr, reg_pc4, reg_imm, load_data;

  assign stall       = (state == ST_WAIT_MEM) & ~bus.dmem_valid_in;
  assign write_ready = (state == ST_RUN) | bus.dmem_valid_in;

  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) state <= ST_RUN;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout_hit)
      next_state = ST_RUN;
    else if (!stall)
      next_state = (bus.valid_in && bus.wb_sel_in == WB_SEL_LOAD) ? ST_WAIT_MEM : ST_RUN;
  end

  // A timed-out load is turned into a bubble so it can never write afterwards
  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      reg_valid         <= 1'b0;
      reg_rf_wr_en      <= 1'b0;
      reg_rd_addr       <= '0;
      reg_wb_sel        <= '0;
      reg_alu           <= '0;
      reg_csr           <= '0;
      reg_pc4           <= '0;
      reg_imm           <= '0;
      reg_load_size     <= '0;
      reg_load_unsigned <= 1'b0;
    end else if (timeout_hit) begin
      reg_valid <= 1'b0;
    end else if (!stall) begin
      reg_valid         <= bus.valid_in;
      reg_rf_wr_en      <= bus.rf_wr_en_in;
      reg_rd_addr       <= bus.rd_addr_in;
      reg_wb_sel        <= bus.wb_sel_in;
      reg_alu           <= bus.alu_result_in;
      reg_csr           <= bus.csr_data_in;
      reg_pc4           <= bus.pc_plus4_in;
      reg_imm           <= bus.imm_in;
      reg_load_size     <= bus.load_size_in;
      reg_load_unsigned <= bus.load_unsigned_in;
    end
  end

  msrv32_load_align u_align (
    .rdata        (bus.dmem_rdata_in),
    .addr         (reg_alu[1:0]),
    .size         (reg_load_size),
    .load_unsigned(reg_load_unsigned),
    .data         (load_data)
  );

  always_comb begin
    case (reg_wb_sel)
      WB_SEL_ALU:  bus.rd_out = reg_alu;
      WB_SEL_LOAD: bus.rd_out = load_data;
      WB_SEL_CSR:  bus.rd_out = reg_csr;
      WB_SEL_PC4:  bus.rd_out = reg_pc4;
      WB_SEL_IMM:  bus.rd_out = reg_imm;
      default:     bus.rd_out = '0;
    endcase
  end

  // x0 is gated here because the register file forwards rd on any address match
  assign bus.rd_addr_out = reg_rd_addr;
  assign bus.wr_en_out   = reg_valid & reg_rf_wr_en & (reg_rd_addr != 5'd0) & write_ready;
  assign bus.stall_out   = stall;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;

  assign timeout_hit = stall && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      fault_q <= timeout_hit;
      if (!stall && next_state == ST_WAIT_MEM) wait_cnt <= '0;
      else if (stall)                          wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign bus.load_fault_out = fault_q;
`else
  assign timeout_hit        = 1'b0;
  assign bus.load_fault_out = 1'b0;
`endif

endmodule
